nec_ir_tx: RTL and testbench



---
 rtl/nec_ir_tx.sv | 185 ++++++++++++++++++
 tb/tb_nec_ir_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises a 32-bit NEC frame or a repeat code as a
// carrier-modulated LED drive, plus an unmodulated envelope and an active-low
// receiver-equivalent line for on-chip loopback.
module nec_ir_tx #(
  parameter int unsigned UNIT_CYCLES  = 56250,
  parameter int unsigned CARRIER_HALF = 1316
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_out,
  output logic       ir_rx_level
);

  localparam int unsigned UnitW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned CarW  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StRepSpace,
    StBitMark,
    StBitSpace,
    StStopMark
  } state_e;

  state_e           state_q, state_d;
  logic [UnitW-1:0] unit_cnt_q, unit_cnt_d;
  logic [4:0]       units_q, units_d;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [31:0]      shift_q, shift_d;
  logic             rep_q, rep_d;
  logic [CarW-1:0]  car_cnt_q, car_cnt_d;
  logic             car_q, car_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             env_q, env_d;
  logic             out_q, out_d;
  logic             rx_q, rx_d;

  logic [4:0] state_len;
  logic       unit_last;
  logic       state_last;
  logic       mark_d;

  // Length of the current state in NEC units; bit spaces depend on the bit being sent.
  always_comb begin
    state_len = 5'd1;
    case (state_q)
      StLeadMark:  state_len = 5'd16;
      StLeadSpace: state_len = 5'd8;
      StRepSpace:  state_len = 5'd4;
      StBitSpace:  state_len = shift_q[0] ? 5'd3 : 5'd1;
      default:     state_len = 5'd1;
    endcase
  end

  assign unit_last  = (unit_cnt_q == UnitW'(UNIT_CYCLES - 1));
  assign state_last = unit_last && (units_q == state_len - 5'd1);

  // Next-state, timing counters, carrier and registered-output decode.
  always_comb begin
    state_d    = state_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    car_cnt_d  = car_cnt_q;
    car_d      = car_q;
    done_d     = 1'b0;

    if (state_q == StIdle) begin
      if (start) begin
        state_d    = StLeadMark;
        shift_d    = {~cmd, cmd, ~addr, addr};
        rep_d      = repeat_req;
        unit_cnt_d = '0;
        units_d    = '0;
        bit_idx_d  = '0;
      end
    end else begin
      if (unit_last) begin
        unit_cnt_d = '0;
        units_d    = units_q + 5'd1;
      end else begin
        unit_cnt_d = unit_cnt_q + UnitW'(1);
      end
      if (state_last) begin
        unit_cnt_d = '0;
        units_d    = '0;
        case (state_q)
          StLeadMark:  state_d = rep_q ? StRepSpace : StLeadSpace;
          StLeadSpace: state_d = StBitMark;
          StRepSpace:  state_d = StStopMark;
          StBitMark:   state_d = StBitSpace;
          StBitSpace: begin
            shift_d = shift_q >> 1;
            if (bit_idx_q == 5'd31) begin
              state_d = StStopMark;
            end else begin
              state_d   = StBitMark;
              bit_idx_d = bit_idx_q + 5'd1;
            end
          end
          StStopMark: begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    mark_d = (state_d == StLeadMark) || (state_d == StBitMark) || (state_d == StStopMark);

    // Every mark starts with a fresh high carrier half-period; spaces hold it low.
    if (mark_d && (state_d != state_q)) begin
      car_cnt_d = '0;
      car_d     = 1'b1;
    end else if (mark_d) begin
      if (car_cnt_q == CarW'(CARRIER_HALF - 1)) begin
        car_cnt_d = '0;
        car_d     = ~car_q;
      end else begin
        car_cnt_d = car_cnt_q + CarW'(1);
      end
    end else begin
      car_cnt_d = '0;
      car_d     = 1'b0;
    end

    busy_d = (state_d != StIdle);
    env_d  = mark_d;
    out_d  = mark_d & car_d;
    rx_d   = ~mark_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      unit_cnt_q <= '0;
      units_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rep_q      <= 1'b0;
      car_cnt_q  <= '0;
      car_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      env_q      <= 1'b0;
      out_q      <= 1'b0;
      rx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rep_q      <= rep_d;
      car_cnt_q  <= car_cnt_d;
      car_q      <= car_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      env_q      <= env_d;
      out_q      <= out_d;
      rx_q       <= rx_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ir_env      = env_q;
  assign ir_out      = out_q;
  assign ir_rx_level = rx_q;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboard bench for nec_ir_tx: stimulus pushes hand-computed frame expectations,
// a negedge monitor measures each frame from the outputs and scores it on done.
module tb_nec_ir_tx;

  localparam int unsigned Unit = 20;
  localparam int unsigned Half = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       repeat_req;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       busy;
  logic       done;
  logic       ir_env;
  logic       ir_out;
  logic       ir_rx_level;

  nec_ir_tx #(
    .UNIT_CYCLES (Unit),
    .CARRIER_HALF(Half)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .repeat_req (repeat_req),
    .addr       (addr),
    .cmd        (cmd),
    .busy       (busy),
    .done       (done),
    .ir_env     (ir_env),
    .ir_out     (ir_out),
    .ir_rx_level(ir_rx_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rep;
    logic [31:0] word;
    int          busy_len;
    time         t_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor state
  logic in_frame  = 1'b0;
  logic prev_busy = 1'b0;
  logic cur_level = 1'b0;
  int   seg_len   = 0;
  int   busy_cnt  = 0;
  int   car_bad   = 0;
  int   segs[$];
  time  t_rise    = 0;
  exp_t cur_e;

  task automatic score(input exp_t e);
    logic [31:0] w;
    int          bad;
    w   = '0;
    bad = 0;
    chk("busy_len", busy_cnt, e.busy_len);
    chk("start_latency", t_rise - e.t_edge, 5);
    chk("carrier_and_levels", car_bad, 0);
    if (segs.size() > 0) chk("lead_mark", segs[0], 320);
    if (e.rep) begin
      chk("rep_seg_count", segs.size(), 3);
      if (segs.size() == 3) begin
        chk("rep_space", segs[1], 80);
        chk("rep_stop_mark", segs[2], 20);
      end
    end else begin
      chk("full_seg_count", segs.size(), 67);
      if (segs.size() == 67) begin
        chk("lead_space", segs[1], 160);
        for (int i = 0; i < 32; i++) begin
          if (segs[2 + 2 * i] != 20) bad++;
          if (segs[3 + 2 * i] == 60) begin
            w[i] = 1'b1;
          end else begin
            w[i] = 1'b0;
            if (segs[3 + 2 * i] != 20) bad++;
          end
        end
        chk("bit_timing", bad, 0);
        chk("frame_word", w, e.word);
        chk("stop_mark", segs[66], 20);
      end
    end
  endtask

  // Measure each frame from busy rise to done pulse, scoring against the queue.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      segs.delete();
    end else begin
      if (!in_frame && !prev_busy && busy) begin
        in_frame  = 1'b1;
        t_rise    = $time;
        segs.delete();
        cur_level = ir_env;
        seg_len   = 0;
        busy_cnt  = 0;
        car_bad   = 0;
        chk("env_rises_with_busy", ir_env, 1);
      end
      if (in_frame) begin
        if (busy) busy_cnt++;
        if (ir_env == cur_level) begin
          seg_len++;
        end else begin
          segs.push_back(seg_len);
          cur_level = ir_env;
          seg_len   = 1;
        end
        if (ir_env) begin
          if (ir_out !== ((((seg_len - 1) / Half) % 2) == 0)) car_bad++;
        end else if (ir_out !== 1'b0) begin
          car_bad++;
        end
        if (ir_rx_level !== ~ir_env) car_bad++;
      end
      if (done) begin
        chk("busy_low_at_done", busy, 0);
        if (!in_frame || exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with no frame pending, expected no pulse");
        end else begin
          cur_e = exp_q.pop_front();
          score(cur_e);
        end
        in_frame = 1'b0;
      end
    end
    prev_busy = busy;
  end

  task automatic launch(input logic rep, input logic [7:0] a, input logic [7:0] c,
                        input logic [31:0] exp_word, input int exp_len,
                        input logic push, input logic hold);
    exp_t e;
    @(negedge clk);
    repeat_req = rep;
    addr       = a;
    cmd        = c;
    start      = 1'b1;
    @(posedge clk);
    if (push) begin
      e.rep      = rep;
      e.word     = exp_word;
      e.busy_len = exp_len;
      e.t_edge   = $time;
      exp_q.push_back(e);
    end
    #1;
    if (!hold) begin
      start      = 1'b0;
      repeat_req = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected a done pulse", budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start      = 1'b1;
    repeat_req = 1'b1;
    addr       = 8'hFF;
    cmd        = 8'hFF;
    @(negedge clk);
    start      = 1'b0;
    repeat_req = 1'b0;
  endtask

  initial begin
    exp_t e2;
    rst        = 1'b1;
    start      = 1'b0;
    repeat_req = 1'b0;
    addr       = '0;
    cmd        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ir_out", ir_out, 0);
    chk("reset_ir_env", ir_env, 0);
    chk("reset_rx_level", ir_rx_level, 1);

    // Full frame, addr 0x00 cmd 0x45
    launch(1'b0, 8'h00, 8'h45, 32'hBA45FF00, 2420, 1'b1, 1'b0);
    wait_done(3000);
    repeat (5) @(negedge clk);

    // Repeat code
    launch(1'b1, 8'h12, 8'h34, 32'h0, 420, 1'b1, 1'b0);
    wait_done(600);
    repeat (5) @(negedge clk);

    // Full frame with starts pulsed mid-frame that must be ignored
    launch(1'b0, 8'h10, 8'h01, 32'hFE01EF10, 2420, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    pulse_start();
    repeat (600) @(negedge clk);
    pulse_start();
    wait_done(3000);
    repeat (5) @(negedge clk);

    // Back-to-back: start held high through done
    launch(1'b0, 8'h00, 8'h45, 32'hBA45FF00, 2420, 1'b1, 1'b1);
    addr = 8'h5A;
    cmd  = 8'hC3;
    wait_done(3000);
    @(posedge clk);
    e2.rep      = 1'b0;
    e2.word     = 32'h3CC3A55A;
    e2.busy_len = 2420;
    e2.t_edge   = $time;
    exp_q.push_back(e2);
    #1;
    start = 1'b0;
    wait_done(3000);
    repeat (5) @(negedge clk);

    // Reset mid-frame: aborted frame yields no done, next frame is intact
    launch(1'b0, 8'h00, 8'h45, 32'h0, 0, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_busy", busy, 0);
    chk("midreset_env", ir_env, 0);
    chk("midreset_out", ir_out, 0);
    chk("midreset_done", done, 0);
    chk("midreset_rx", ir_rx_level, 1);
    repeat (30) @(negedge clk);
    launch(1'b0, 8'h00, 8'h18, 32'hE718FF00, 2420, 1'b1, 1'b0);
    wait_done(3000);

    repeat (40) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
